// File: rtl/twelve_down.sv
// Mod-12 down-counter with clamped parallel load, one-cycle borrow pulse and an
// optional one-shot mode that parks at zero in a DONE state until reloaded or released.
module twelve_down (
    input  logic       CLK,
    input  logic       MR,
    input  logic       EN,
    input  logic       LD,
    input  logic [3:0] D,
    input  logic       ONESHOT,
    output logic [3:0] Q,
    output logic       BO,
    output logic       DONE
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] q_nxt;
    logic       bo_nxt;

    // Out-of-range load values saturate to the top count so Q stays within 0..11.
    function automatic logic [3:0] clamp_load(input logic [3:0] v);
        return (v > 4'd11) ? 4'd11 : v;
    endfunction

    always_ff @(posedge CLK or posedge MR) begin
        if (MR) begin
            state <= S_RUN;
            Q     <= 4'd0;
            BO    <= 1'b0;
        end else begin
            state <= state_nxt;
            Q     <= q_nxt;
            BO    <= bo_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = Q;
        bo_nxt    = 1'b0;
        if (LD) begin
            q_nxt     = clamp_load(D);
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    if (EN) begin
                        if (Q != 4'd0) begin
                            q_nxt = Q - 4'd1;
                        end else begin
                            bo_nxt = 1'b1;
                            if (ONESHOT) begin
                                state_nxt = S_DONE;
                            end else begin
                                q_nxt = 4'd11;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // Leaving DONE only re-arms; the wrap happens on a later enabled edge.
                    q_nxt = 4'd0;
                    if (!ONESHOT) begin
                        state_nxt = S_RUN;
                    end
                end
                default: begin
                    state_nxt = S_RUN;
                    q_nxt     = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        DONE = (state == S_DONE);
    end

endmodule

// File: doc/twelve_down.md
# twelve_down

Mod-12 down-counter with parallel load, borrow output and an optional one-shot (count-to-zero-and-stop) mode. It is the counting-down counterpart of the team's mod-12 up-counter. It shares that counter's clock, reset and enable port names, so the two can be cascaded or swapped on the lab board. It is used as a preset countdown timer or as the low digit of a multi-digit down-counting chain, with BO driving the next stage's EN.

## Interface
- No parameters. Modulus is fixed at 12; count width is fixed at 4.
- CLK  input  1  System clock; all state changes on the rising edge.
- MR  input  1  Reset, asynchronous, active-high. While MR=1: Q=0, BO=0, state=RUN.
- EN  input  1  Count enable; active-high.
- LD  input  1  Synchronous parallel load; active-high.
- D  input  4  Load value.
- ONESHOT  input  1  Mode select. 1 = stop at 0. 0 = cyclic wrap 0→11.
- Q  output  4  Current count, range 0..11.
- BO  output  1  Borrow. Registered, one-cycle pulse.
- DONE  output  1  High while the state machine is in DONE. Registered; derived from state.

## Operation
- States:
  - RUN: counting.
  - DONE: one-shot expired; Q held at 0.
- Priority at each rising edge: MR (async) > LD > count > hold.
- LD=1, in any state:
  - Q ← D if D≤11, else Q ← 11 (clamp).
  - State → RUN.
  - BO ← 0.
  - EN and ONESHOT are ignored on that edge.
- RUN, LD=0, EN=1:
  - Q>0: Q ← Q−1, BO ← 0.
  - Q=0, ONESHOT=0: Q ← 11, BO ← 1.
  - Q=0, ONESHOT=1: Q stays 0, BO ← 1, state → DONE.
- RUN, LD=0, EN=0: Q held, BO ← 0.
- DONE, LD=0:
  - Q held at 0, BO ← 0, EN ignored.
  - If ONESHOT=0 at the edge, state → RUN without counting.
  - The next enabled edge after that wraps Q to 11 and pulses BO.
- Q never takes the values 12..15. No input sequence may produce them.
- Changing ONESHOT in RUN takes effect at the next Q=0 borrow decision.
- DONE = (state==DONE).

## Timing
- Reset: asynchronous assert. Q, BO and DONE go to 0 without a clock edge. Release is synchronous to the next edge; the first edge after MR falls can count or load.
- Load latency: 1 edge. Q shows the loaded value in the cycle after the LD edge.
- Count latency: 1 edge per decrement.
- BO is high for exactly one clock cycle, the cycle following the borrowing edge.
  - Cyclic mode: BO=1 coincides with Q=11.
  - One-shot mode: BO=1 coincides with Q=0 and DONE=1.
- With EN held at 1 in cyclic mode, BO has a period of exactly 12 cycles.
- LD and EN asserted on the same edge with Q=0: the load wins and no BO pulse occurs.
- MR asserted mid-pulse: BO drops immediately.
- MR asserted in DONE: state returns to RUN and Q=0. With ONESHOT=1 and EN=1, the first edge after release re-enters DONE with a BO pulse.

## Test plan
- Async reset: count to Q=6, raise MR between edges → Q=0, BO=0, DONE=0 immediately. Q stays 0 for 3 edges while MR=1.
- Cyclic wrap: ONESHOT=0, EN=1 from Q=0 for 26 cycles → Q=11,10,…,0,11,…. BO=1 only in the cycles where Q=11 after a wrap, 12 cycles apart. Q never exceeds 11.
- Load, clamp and hold:
  - LD=1, D=5 → Q=5 next cycle.
  - LD=1, D=14 → Q=11.
  - LD=1, D=0 with EN=1 at Q=0 → Q=0, BO=0.
  - EN=0 for 5 cycles at Q=7 → Q stays 7, BO=0.
- One-shot:
  - ONESHOT=1, load 3, EN=1 → Q=2,1,0. Next edge: DONE=1 and BO=1 for one cycle.
  - Q then holds 0 for 10 further enabled cycles with BO=0.
  - LD=1, D=2 → DONE=0, Q=2, and counting resumes.
- Mode switch in DONE: in DONE, set ONESHOT=0 → DONE=0 after one edge with Q=0 and no BO. The next enabled edge gives Q=11, BO=1.
- Cascade: two instances, with the low digit's BO driving the high digit's EN. Both cyclic and both loaded with 0 → the high digit decrements once every 12 cycles. The combined count reaches 0/0 after 144 cycles, and the high digit's BO pulses once at the 144-cycle wrap.
